seq_browser: RTL and testbench
==============================

# seq_browser

Parametrised result-sequence buffer with bidirectional browsing. Captures WIDTH-bit results from an upstream FSM on a write strobe into a DEPTH-entry circular store and exposes one selected entry for the seven-segment display path. Navigation pulses come from the debounced button filters. It replaces the fixed 10×32 sequence array with the next/wrap logic in the lab top level, adding step-back, full/overflow reporting and an optional overwrite-oldest mode.

## Interface
- WIDTH, 32, entry width in bits.
- DEPTH, 10, number of entries; must be ≥2 and need not be a power of two.
- IW (localparam), $clog2(DEPTH), index width.
- CW (localparam), $clog2(DEPTH+1), count width.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high.
- wr_en  in  1  write strobe; one write per high cycle.
- wr_data  in  WIDTH  result to store.
- nxt  in  1  step view forward; one step per high cycle.
- prv  in  1  step view back; one step per high cycle.
- view_data  out  WIDTH  entry at view_idx; 0 when empty.
- view_idx  out  IW  logical index of the viewed entry (0 = oldest).
- count  out  CW  number of valid entries, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- ovf  out  1  one-cycle pulse on a write that arrives while the buffer is full.

## Operation
- State: head (physical index of the oldest entry), count, view_idx, and the storage array.
- Physical address of logical index k is (head+k) mod DEPTH. The wrap uses a compare-and-subtract, never bit truncation.
- Write while not full: store at the physical address of logical index count, then count+1.
- Write while full: ovf=1 for that cycle. The non-overwrite behaviour is described under Configuration.
- nxt only: view_idx+1, or 0 if view_idx+1 ≥ count.
- prv only: view_idx−1, or count−1 if view_idx==0.
- nxt and prv together: view_idx unchanged.
- Empty buffer: nxt and prv leave view_idx at 0.
- Navigation is evaluated against count before the same-cycle write.
- After navigation, an eviction (overwrite mode) decrements view_idx if it is >0, so the view keeps the same entry. If view_idx is 0, it stays 0 and shows the new oldest entry.
- view_data: combinational read of the registered storage at the physical view address, forced to 0 when empty.
- full, empty: decoded from count.

## Timing
- Reset values:
  - head=0, count=0, view_idx=0.
  - full=0, empty=1, ovf=0, view_data=0.
  - Storage is not cleared; it is masked by count.
- Reset has priority over wr_en, nxt and prv in the same cycle.
- Reset mid-sequence discards all entries at the next edge.
- Latency: a strobe sampled at edge N is reflected on count, view_idx and view_data after edge N. There is no further pipeline.
- ovf is high exactly for the cycle following the offending strobe edge and is registered.
- Inputs are level-sampled. Upstream must deliver single-cycle pulses; a held level acts every cycle.

## Configuration
- SEQ_BROWSER_OVERWRITE_EN defined:
  - A write while full replaces the oldest entry at head.
  - head advances mod DEPTH; count stays DEPTH.
  - The view_idx adjustment above applies.
  - ovf pulses.
- SEQ_BROWSER_OVERWRITE_EN undefined:
  - A write while full is dropped.
  - Storage, head, count and view_idx are unchanged.
  - ovf pulses.

## Structure
- Shared package seq_browser_pkg:
  - wrap-increment and wrap-decrement functions for non-power-of-two modulus (index, limit);
  - the IW/CW width helper.
- One sub-module, seq_store: WIDTH×DEPTH register file with one synchronous write port and one asynchronous read port, no reset.
- Pointer, count and view logic stays in seq_browser.

## Test plan
Benches run with WIDTH=8, DEPTH=4.
1. Reset, then write 0x11, 0x22, 0x33 → count=3, view_idx=0, view_data=0x11. Three nxt pulses → 0x22, 0x33, 0x11 (wraps to idx 0).
2. With count=3 and view_idx=0, one prv → idx 2, view_data=0x33. nxt and prv in the same cycle → idx stays 2. On an empty buffer, nxt/prv → idx 0, view_data=0, empty=1.
3. Write 0x11..0x44 → full=1. Write 0x55 with the macro undefined → ovf high one cycle; count=4; idx0..3 read 0x11..0x44.
4. Same fill, macro defined, view_idx=2 (0x33). Write 0x55 → ovf pulse; view_idx=1 still shows 0x33; idx0=0x22, idx3=0x55.
5. Same fill, macro defined, view_idx=0. Write 0x55 → view_idx=0, view_data=0x22.
6. Assert reset in the same cycle as wr_en=1 (data 0x99) and nxt=1 → after the edge: count=0, empty=1, view_idx=0, view_data=0, ovf=0. The next write of 0x99 → view_data=0x99.

Source files
------------

// File: rtl/seq_browser_pkg.sv
// seq_browser_pkg: width helpers and non-power-of-two wrap arithmetic shared by seq_browser.
package seq_browser_pkg;

    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int wrap_inc(input int idx, input int limit);
        return (idx + 1 >= limit) ? 0 : idx + 1;
    endfunction

    function automatic int wrap_dec(input int idx, input int limit);
        return (idx == 0) ? limit - 1 : idx - 1;
    endfunction

    function automatic int wrap_add(input int a, input int b, input int limit);
        return (a + b >= limit) ? a + b - limit : a + b;
    endfunction

endpackage

// File: rtl/seq_browser_if.sv
// seq_browser_if: write/navigation strobes and view/status outputs of seq_browser.
interface seq_browser_if
    import seq_browser_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 10
) ();
    localparam int IW = idx_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             nxt;
    logic             prv;
    logic [WIDTH-1:0] view_data;
    logic [IW-1:0]    view_idx;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             ovf;

    modport master (
        output wr_en, wr_data, nxt, prv,
        input  view_data, view_idx, count, full, empty, ovf
    );

    modport slave (
        input  wr_en, wr_data, nxt, prv,
        output view_data, view_idx, count, full, empty, ovf
    );
endinterface

// File: rtl/seq_store.sv
// seq_store: WIDTH x DEPTH register file, one synchronous write port, one asynchronous read port, no reset.
module seq_store #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 10,
    parameter int IW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [IW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    // capture one entry per write strobe
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/seq_browser.sv
// seq_browser: circular result buffer with forward/back browsing; SEQ_BROWSER_OVERWRITE_EN makes a full write evict the oldest entry.
module seq_browser
    import seq_browser_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 10
) (
    input logic        clk,
    input logic        reset,
    seq_browser_if.slave bus
);
    localparam int IW = idx_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [IW-1:0]    head, head_n, view, view_n, nav, waddr, raddr;
    logic [CW-1:0]    count, count_n;
    logic             ovf, full, empty, accept, evict, we;
    logic [WIDTH-1:0] rdata;

    assign full   = count == CW'(DEPTH);
    assign empty  = count == '0;
    assign accept = bus.wr_en && !full;
`ifdef SEQ_BROWSER_OVERWRITE_EN
    assign evict  = bus.wr_en && full;
`else
    assign evict  = 1'b0;
`endif
    assign we     = accept || evict;

    // navigation against the pre-write count, then shift the view so it keeps its entry across an eviction
    always_comb begin
        nav     = (empty || bus.nxt == bus.prv) ? view
                : bus.nxt ? IW'(wrap_inc(int'(view), int'(count)))
                : IW'(wrap_dec(int'(view), int'(count)));
        view_n  = (evict && nav != '0) ? nav - IW'(1) : nav;
        head_n  = evict ? IW'(wrap_inc(int'(head), DEPTH)) : head;
        count_n = accept ? count + CW'(1) : count;
        waddr   = full ? head : IW'(wrap_add(int'(head), int'(count), DEPTH));
        raddr   = IW'(wrap_add(int'(head), int'(view), DEPTH));
    end

    // pointer, count, view and overflow-pulse registers
    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            count <= '0;
            view  <= '0;
            ovf   <= 1'b0;
        end else begin
            head  <= head_n;
            count <= count_n;
            view  <= view_n;
            ovf   <= bus.wr_en && full;
        end
    end

    seq_store #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IW(IW)) u_store (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (bus.wr_data),
        .raddr (raddr),
        .rdata (rdata)
    );

    assign bus.view_data = empty ? '0 : rdata;
    assign bus.view_idx  = view;
    assign bus.count     = count;
    assign bus.full      = full;
    assign bus.empty     = empty;
    assign bus.ovf       = ovf;
endmodule

// File: tb/tb_seq_browser.sv
// tb_seq_browser: directed vector table plus overflow sequences for seq_browser (WIDTH=8, DEPTH=4), honouring SEQ_BROWSER_OVERWRITE_EN.
module tb_seq_browser;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
`ifdef SEQ_BROWSER_OVERWRITE_EN
    localparam bit OVW = 1'b1;
`else
    localparam bit OVW = 1'b0;
`endif

    typedef struct {
        logic       rst;
        logic       wr;
        logic [7:0] d;
        logic       n;
        logic       p;
        int         cnt;
        int         idx;
        int         data;
        int         ovf;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    vec_t v[18];

    seq_browser_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    seq_browser #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic w, input logic [7:0] d, input logic n, input logic p);
        reset       = r;
        bus.wr_en   = w;
        bus.wr_data = d;
        bus.nxt     = n;
        bus.prv     = p;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        bus.wr_en = 1'b0;
        bus.nxt   = 1'b0;
        bus.prv   = 1'b0;
    endtask

    task automatic expect_state(input string tag, input int cnt, input int idx, input int data, input int ovf);
        check({tag, " count"}, int'(bus.count), cnt);
        check({tag, " view_idx"}, int'(bus.view_idx), idx);
        check({tag, " view_data"}, int'(bus.view_data), data);
        check({tag, " full"}, int'(bus.full), int'(cnt == DEPTH));
        check({tag, " empty"}, int'(bus.empty), int'(cnt == 0));
        check({tag, " ovf"}, int'(bus.ovf), ovf);
    endtask

    task automatic fill();
        step(1, 0, 8'h00, 0, 0);
        step(0, 1, 8'h11, 0, 0);
        step(0, 1, 8'h22, 0, 0);
        step(0, 1, 8'h33, 0, 0);
        step(0, 1, 8'h44, 0, 0);
        expect_state("fill", 4, 0, 'h11, 0);
    endtask

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        bus.nxt     = 1'b0;
        bus.prv     = 1'b0;
        //        rst wr d      n  p  cnt idx data  ovf
        v[0]  = '{1, 0, 8'h00, 0, 0, 0, 0, 'h00, 0};
        v[1]  = '{0, 1, 8'h11, 0, 0, 1, 0, 'h11, 0};
        v[2]  = '{0, 1, 8'h22, 0, 0, 2, 0, 'h11, 0};
        v[3]  = '{0, 1, 8'h33, 0, 0, 3, 0, 'h11, 0};
        v[4]  = '{0, 0, 8'h00, 1, 0, 3, 1, 'h22, 0};
        v[5]  = '{0, 0, 8'h00, 1, 0, 3, 2, 'h33, 0};
        v[6]  = '{0, 0, 8'h00, 1, 0, 3, 0, 'h11, 0};
        v[7]  = '{0, 0, 8'h00, 0, 1, 3, 2, 'h33, 0};
        v[8]  = '{0, 0, 8'h00, 1, 1, 3, 2, 'h33, 0};
        v[9]  = '{0, 1, 8'h44, 0, 0, 4, 2, 'h33, 0};
        v[10] = '{1, 0, 8'h00, 0, 0, 0, 0, 'h00, 0};
        v[11] = '{0, 0, 8'h00, 1, 0, 0, 0, 'h00, 0};
        v[12] = '{0, 0, 8'h00, 0, 1, 0, 0, 'h00, 0};
        v[13] = '{1, 1, 8'h99, 1, 0, 0, 0, 'h00, 0};
        v[14] = '{0, 1, 8'h99, 0, 0, 1, 0, 'h99, 0};
        v[15] = '{0, 0, 8'h00, 1, 0, 1, 0, 'h99, 0};
        v[16] = '{0, 0, 8'h00, 0, 1, 1, 0, 'h99, 0};
        v[17] = '{0, 1, 8'hAA, 1, 0, 2, 0, 'h99, 0};
        for (int i = 0; i < 18; i++) begin
            step(v[i].rst, v[i].wr, v[i].d, v[i].n, v[i].p);
            expect_state($sformatf("vec%0d", i), v[i].cnt, v[i].idx, v[i].data, v[i].ovf);
        end

        // full write with view on the third entry
        fill();
        step(0, 0, 8'h00, 1, 0);
        step(0, 0, 8'h00, 1, 0);
        expect_state("pre_ovf", 4, 2, 'h33, 0);
        step(0, 1, 8'h55, 0, 0);
        expect_state("ovf_write", 4, OVW ? 1 : 2, 'h33, 1);
        step(0, 0, 8'h00, 0, 0);
        expect_state("ovf_clear", 4, OVW ? 1 : 2, 'h33, 0);
        step(0, 0, 8'h00, 1, 0);
        expect_state("walk_a", 4, OVW ? 2 : 3, 'h44, 0);
        step(0, 0, 8'h00, 1, 0);
        expect_state("walk_b", 4, OVW ? 3 : 0, OVW ? 'h55 : 'h11, 0);
        step(0, 0, 8'h00, 1, 0);
        expect_state("walk_c", 4, OVW ? 0 : 1, OVW ? 'h22 : 'h22, 0);

        // full write with view on the oldest entry, then a held write level
        fill();
        step(0, 1, 8'h55, 0, 0);
        expect_state("ovf_oldest", 4, 0, OVW ? 'h22 : 'h11, 1);
        step(0, 1, 8'h66, 0, 0);
        expect_state("ovf_held", 4, 0, OVW ? 'h33 : 'h11, 1);
        step(0, 0, 8'h00, 0, 1);
        expect_state("ovf_back", 4, 3, OVW ? 'h66 : 'h44, 0);

        // reset mid-sequence discards everything
        step(1, 0, 8'h00, 0, 0);
        expect_state("reset_mid", 0, 0, 'h00, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
